// File: rtl/seq_pattern_detector_pkg.sv
// Shared types and helpers for the serial pattern detector.
package seq_pkg;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      ARMED   = 2'd2
   } state_e;

   // Fill counter must represent 0..pat_len inclusive.
   function automatic int fill_w(input int pat_len);
      return $clog2(pat_len + 1);
   endfunction

endpackage

// File: rtl/seq_pattern_detector_if.sv
// Bit-stream input and detection result bundle for seq_pattern_detector.
interface seq_pattern_detector_if #(
   parameter int PAT_LEN = 4,
   parameter int CNT_W   = 8
);
   logic               din_valid;
   logic               din;
   logic               clr;
   logic               match;
   logic [CNT_W-1:0]   match_cnt;
   logic               armed;
   logic [PAT_LEN-1:0] window;

   modport master (
      output din_valid, din, clr,
      input  match, match_cnt, armed, window
   );

   modport slave (
      input  din_valid, din, clr,
      output match, match_cnt, armed, window
   );
endinterface

// File: rtl/seq_pattern_detector_shift_window.sv
// Enabled shift register with synchronous flush and a saturating fill counter.
module shift_window
   import seq_pkg::*;
#(
   parameter int PAT_LEN = 4,
   parameter int FILL_W  = fill_w(PAT_LEN)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               shift_i,
   input  logic               flush_i,
   input  logic               din_i,
   output logic [PAT_LEN-1:0] window_o,
   output logic [FILL_W-1:0]  fill_o
);

   localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_LEN);

   logic [PAT_LEN-1:0] window_q, window_d;
   logic [FILL_W-1:0]  fill_q, fill_d;

   // Flush wins over shift so a discarded bit never lands in the window.
   always_comb begin
      window_d = window_q;
      fill_d   = fill_q;
      if (flush_i) begin
         window_d = '0;
         fill_d   = '0;
      end else if (shift_i) begin
         window_d = {window_q[PAT_LEN-2:0], din_i};
         fill_d   = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         window_q <= '0;
         fill_q   <= '0;
      end else begin
         window_q <= window_d;
         fill_q   <= fill_d;
      end
   end

   assign window_o = window_q;
   assign fill_o   = fill_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: one-cycle match pulse, saturating match count, fill-level FSM.
module seq_pattern_detector
   import seq_pkg::*;
#(
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
   parameter bit                 OVERLAP = 1'b1,
   parameter int                 CNT_W   = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   seq_pattern_detector_if.slave   bus
);

   localparam int                FILL_W = fill_w(PAT_LEN);
   localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_LEN);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   logic [PAT_LEN-1:0] win, win_nxt;
   logic [FILL_W-1:0]  fill, fill_nxt;
   logic               shift, flush, hit;

   state_e             state_q, state_d;
   logic               match_q, match_d;
   logic               armed_q;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   // Compare against the window as it will look after this bit is shifted in.
   always_comb begin
      win_nxt  = {win[PAT_LEN-2:0], bus.din};
      fill_nxt = (fill == FULL) ? fill : fill + 1'b1;
      shift    = bus.din_valid && !bus.clr;
      hit      = shift && (fill_nxt == FULL) && (win_nxt == PATTERN);
      flush    = bus.clr || (hit && !OVERLAP);
   end

   shift_window #(
      .PAT_LEN (PAT_LEN),
      .FILL_W  (FILL_W)
   ) u_window (
      .clk      (clk),
      .rst      (rst),
      .shift_i  (shift),
      .flush_i  (flush),
      .din_i    (bus.din),
      .window_o (win),
      .fill_o   (fill)
   );

   always_comb begin
      state_d = state_q;
      match_d = 1'b0;
      cnt_d   = cnt_q;
      if (bus.clr) begin
         state_d = EMPTY;
         cnt_d   = '0;
      end else if (bus.din_valid) begin
         match_d = hit;
         if (hit) cnt_d = sat_inc(cnt_q);
         if (hit && !OVERLAP) begin
            state_d = EMPTY;
         end else begin
            unique case (state_q)
               EMPTY:   state_d = (fill_nxt == FULL) ? ARMED : FILLING;
               FILLING: state_d = (fill_nxt == FULL) ? ARMED : FILLING;
               ARMED:   state_d = ARMED;
               default: state_d = EMPTY;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= EMPTY;
         match_q <= 1'b0;
         armed_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         match_q <= match_d;
         armed_q <= (state_d == ARMED);
         cnt_q   <= cnt_d;
      end
   end

   assign bus.match     = match_q;
   assign bus.match_cnt = cnt_q;
   assign bus.armed     = armed_q;
   assign bus.window    = win;

endmodule
